// File: rtl/hwag_coil_sched.sv
// rtl/hwag_coil_sched.sv - multi-channel ignition coil scheduler driven by the hwag angle counter
//
// One shared comparator walks all channels, one per clk, after every angle
// tick. Channel config is written to pending registers and copied to the
// active set only when a scan begins at angle 0, so a revolution never tears.
//
// Ports:
//   clk, rst_n          system clock (posedge), asynchronous active-low reset
//   en, sync            global enable and angle-counter lock; both must be high to schedule
//   angle_stb, angle    1-clk tick pulse and the new angle value (0..ANG_TOP)
//   cfg_we, cfg_ch,
//   cfg_sel, cfg_data   pending config write: sel 0 = fire angle, 1 = charge width
//   ovf_clr             clears the sticky overrun flag
//   coil_out            per-channel coil drive, 1 = charging
//   busy                a channel scan is in progress
//   ovf                 sticky: a tick arrived while a scan and a pended tick were both outstanding
module hwag_coil_sched #(
    parameter int CH_NUM    = 4,
    parameter int ANG_W     = 12,
    parameter int ANG_TOP   = 3839,
    parameter int DWELL_W   = 24,
    parameter int DWELL_MAX = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic              angle_stb,
    input  logic [ANG_W-1:0]  angle,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic              cfg_sel,
    input  logic [ANG_W-1:0]  cfg_data,
    input  logic              ovf_clr,
    output logic [CH_NUM-1:0] coil_out,
    output logic              busy,
    output logic              ovf
);

    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(CH_NUM - 1);
    localparam logic [ANG_W-1:0]   ANG_MAX    = ANG_W'(ANG_TOP);
    localparam logic [ANG_W:0]     ANG_REV    = (ANG_W + 1)'(ANG_TOP + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_MAX - 1);

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ANG_W-1:0] ang_q, ang_d;
    logic             pend_q, pend_d;
    logic [ANG_W-1:0] pend_ang_q, pend_ang_d;
    logic             ovf_q;
    logic             ovf_set;
    logic             start_scan;
    logic             eval_en;
    logic             run;
    logic             cfg_ok;
    logic             load;

    assign run    = en & sync;
    assign cfg_ok = cfg_we && ({29'b0, cfg_ch} < 32'(CH_NUM)) && (cfg_data <= ANG_MAX);
    // Shadow load happens on the same edge the scan starts, so channel 0
    // already compares against the new revolution's values.
    assign load   = start_scan && (ang_d == '0);

    assign busy = (state_q == ST_SCAN);
    assign ovf  = ovf_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ang_d      = ang_q;
        pend_d     = pend_q;
        pend_ang_d = pend_ang_q;
        ovf_set    = 1'b0;
        start_scan = 1'b0;
        eval_en    = 1'b0;
        if (!run) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A pended tick is older than one arriving now; the new
                    // one takes its place in the 1-deep pending slot.
                    if (pend_q) begin
                        start_scan = 1'b1;
                        ang_d      = pend_ang_q;
                        pend_d     = angle_stb;
                        pend_ang_d = angle;
                        state_d    = ST_SCAN;
                        idx_d      = '0;
                    end else if (angle_stb) begin
                        start_scan = 1'b1;
                        ang_d      = angle;
                        state_d    = ST_SCAN;
                        idx_d      = '0;
                    end
                end
                ST_SCAN: begin
                    eval_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (angle_stb) begin
                        if (pend_q) begin
                            ovf_set = 1'b1;
                        end else begin
                            pend_d     = 1'b1;
                            pend_ang_d = angle;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            ang_q      <= '0;
            pend_q     <= 1'b0;
            pend_ang_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ang_q      <= ang_d;
            pend_q     <= pend_d;
            pend_ang_q <= pend_ang_d;
            ovf_q      <= ovf_set | (ovf_q & ~ovf_clr);
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [ANG_W-1:0]   pend_ign_q, pend_chrg_q;
        logic [ANG_W-1:0]   act_ign_q, act_chrg_q, start_q;
        logic [ANG_W-1:0]   start_calc;
        logic [DWELL_W-1:0] dwell_q;
        logic               coil_q;
        logic               sel_me, fire, charge, dwell_done;

        // Charge start is the fire angle minus the window, modulo one revolution.
        assign start_calc = (pend_ign_q >= pend_chrg_q) ? (pend_ign_q - pend_chrg_q)
                          : ANG_W'({1'b0, pend_ign_q} + ANG_REV - {1'b0, pend_chrg_q});

        assign sel_me     = eval_en && (idx_q == IDX_W'(g));
        assign fire       = sel_me && (ang_q == act_ign_q);
        assign charge     = sel_me && (act_chrg_q != '0) && (ang_q == start_q);
        assign dwell_done = (dwell_q == DWELL_LAST);
        assign coil_out[g] = coil_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_ign_q  <= '0;
                pend_chrg_q <= '0;
            end else if (cfg_ok && (cfg_ch == 3'(g))) begin
                if (cfg_sel) begin
                    pend_chrg_q <= cfg_data;
                end else begin
                    pend_ign_q <= cfg_data;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_ign_q  <= '0;
                act_chrg_q <= '0;
                start_q    <= '0;
            end else if (load) begin
                act_ign_q  <= pend_ign_q;
                act_chrg_q <= pend_chrg_q;
                start_q    <= start_calc;
            end
        end

        // Dwell limit runs every clk regardless of the scan; once forced off
        // the coil only restarts on a later start-angle match.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                coil_q  <= 1'b0;
                dwell_q <= '0;
            end else if (!run) begin
                coil_q  <= 1'b0;
                dwell_q <= '0;
            end else if (coil_q) begin
                if (dwell_done || fire) begin
                    coil_q  <= 1'b0;
                    dwell_q <= '0;
                end else begin
                    dwell_q <= dwell_q + DWELL_W'(1);
                end
            end else if (charge) begin
                coil_q  <= 1'b1;
                dwell_q <= '0;
            end
        end
    end

endmodule
